// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg: shared widths, reset/NOP constants, skid-buffer state encodings and lane-slice helper
package mem_wb_pipe_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam int MaxLanes = 4;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic RstEnable = 1'b1;
  typedef enum logic [1:0] {
    WBQ_EMPTY = 2'b00,
    WBQ_ONE   = 2'b01,
    WBQ_FULL  = 2'b10
  } wbq_state_t;
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/mem_wb_pipe_lane_sanitise.sv
// wb_lane_sanitise: clears wreg for $0 destinations and for lower lanes that collide with a higher lane (addr/wreg in, wreg_san out)
module wb_lane_sanitise
  import mem_wb_pipe_pkg::*;
#(
  parameter int ADDR_W = RegAddrBus,
  parameter int LANES = 1
) (
  input  logic [LANES*ADDR_W-1:0] addr,
  input  logic [LANES-1:0]        wreg,
  output logic [LANES-1:0]        wreg_san
);
  always_comb begin
    wreg_san = wreg;
    for (int i = 0; i < LANES; i++) begin
      if (addr[lane_lsb(i, ADDR_W) +: ADDR_W] == ADDR_W'(NOPRegAddr)) wreg_san[i] = 1'b0;
      for (int j = i + 1; j < LANES; j++)
        if (wreg[i] && wreg[j] && addr[lane_lsb(i, ADDR_W) +: ADDR_W] == addr[lane_lsb(j, ADDR_W) +: ADDR_W])
          wreg_san[i] = 1'b0;
    end
  end
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB stage, 2-entry skid buffer; in: clk rst flush mem_valid mem_dest_addr mem_wreg mem_dest_data wb_ready; out: mem_ready wb_valid wb_dest_addr wb_wreg wb_dest_data; MEM_WB_HILO_EN adds mem_whilo/mem_hi/mem_lo and wb_whilo/wb_hi/wb_lo
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int LANES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [LANES*ADDR_W-1:0] mem_dest_addr,
  input  logic [LANES-1:0]        mem_wreg,
  input  logic [LANES*DATA_W-1:0] mem_dest_data,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [LANES*ADDR_W-1:0] wb_dest_addr,
  output logic [LANES-1:0]        wb_wreg,
  output logic [LANES*DATA_W-1:0] wb_dest_data
`ifdef MEM_WB_HILO_EN
  ,
  input  logic                    mem_whilo,
  input  logic [DATA_W-1:0]       mem_hi,
  input  logic [DATA_W-1:0]       mem_lo,
  output logic                    wb_whilo,
  output logic [DATA_W-1:0]       wb_hi,
  output logic [DATA_W-1:0]       wb_lo
`endif
);
  wbq_state_t state, state_nxt;
  logic accept, pop, load_h, load_s, shift;
  logic [LANES-1:0] in_wreg, h_wreg, s_wreg;
  logic [LANES*ADDR_W-1:0] h_addr, s_addr;
  logic [LANES*DATA_W-1:0] h_data, s_data;
`ifdef MEM_WB_HILO_EN
  logic h_whilo, s_whilo;
  logic [DATA_W-1:0] h_hi, h_lo, s_hi, s_lo;
`endif
  wb_lane_sanitise #(.ADDR_W(ADDR_W), .LANES(LANES)) u_san (
    .addr     (mem_dest_addr),
    .wreg     (mem_wreg),
    .wreg_san (in_wreg)
  );
  always_ff @(posedge clk) begin
    if (rst == RstEnable) state <= WBQ_EMPTY;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = flush                ? WBQ_EMPTY :
                state == WBQ_EMPTY   ? (accept ? WBQ_ONE : WBQ_EMPTY) :
                state == WBQ_ONE     ? (accept && !pop ? WBQ_FULL : (!accept && pop ? WBQ_EMPTY : WBQ_ONE)) :
                state == WBQ_FULL    ? (pop ? WBQ_ONE : WBQ_FULL) : WBQ_EMPTY;
  end
  always_comb begin
    wb_valid     = state != WBQ_EMPTY;
    mem_ready    = state != WBQ_FULL;
    accept       = mem_valid & mem_ready;
    pop          = wb_valid & wb_ready;
    load_h       = accept && (state == WBQ_EMPTY || (state == WBQ_ONE && pop));
    load_s       = accept && state == WBQ_ONE && !pop;
    shift        = state == WBQ_FULL && pop;
    wb_wreg      = wb_valid ? h_wreg : '0;
    wb_dest_addr = wb_valid ? h_addr : '0;
    wb_dest_data = wb_valid ? h_data : '0;
`ifdef MEM_WB_HILO_EN
    wb_whilo     = wb_valid & h_whilo;
    wb_hi        = wb_valid ? h_hi : '0;
    wb_lo        = wb_valid ? h_lo : '0;
`endif
  end
  // Payload registers need no reset: every output is gated by wb_valid.
  always_ff @(posedge clk) begin
    if (load_h) begin
      h_wreg <= in_wreg;
      h_addr <= mem_dest_addr;
      h_data <= mem_dest_data;
    end else if (shift) begin
      h_wreg <= s_wreg;
      h_addr <= s_addr;
      h_data <= s_data;
    end
    if (load_s) begin
      s_wreg <= in_wreg;
      s_addr <= mem_dest_addr;
      s_data <= mem_dest_data;
    end
  end
`ifdef MEM_WB_HILO_EN
  always_ff @(posedge clk) begin
    if (load_h) begin
      h_whilo <= mem_whilo;
      h_hi    <= mem_hi;
      h_lo    <= mem_lo;
    end else if (shift) begin
      h_whilo <= s_whilo;
      h_hi    <= s_hi;
      h_lo    <= s_lo;
    end
    if (load_s) begin
      s_whilo <= mem_whilo;
      s_hi    <= mem_hi;
      s_lo    <= mem_lo;
    end
  end
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed self-checking bench for mem_wb_pipe with LANES=2 (HI/LO checks when MEM_WB_HILO_EN is defined)
module tb_mem_wb_pipe;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LANES = 2;
  logic clk = 1'b0;
  logic rst, flush, mem_valid, mem_ready, wb_valid, wb_ready;
  logic [LANES*ADDR_W-1:0] mem_dest_addr, wb_dest_addr;
  logic [LANES-1:0] mem_wreg, wb_wreg;
  logic [LANES*DATA_W-1:0] mem_dest_data, wb_dest_data;
  logic [76:0] obs, exp;
  int errors = 0;
  int checks = 0;
`ifdef MEM_WB_HILO_EN
  logic mem_whilo, wb_whilo;
  logic [DATA_W-1:0] mem_hi, mem_lo, wb_hi, wb_lo;
`endif
  always #5 clk = ~clk;
  mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_dest_addr (mem_dest_addr),
    .mem_wreg      (mem_wreg),
    .mem_dest_data (mem_dest_data),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_dest_addr  (wb_dest_addr),
    .wb_wreg       (wb_wreg),
    .wb_dest_data  (wb_dest_data)
`ifdef MEM_WB_HILO_EN
    ,
    .mem_whilo     (mem_whilo),
    .mem_hi        (mem_hi),
    .mem_lo        (mem_lo),
    .wb_whilo      (wb_whilo),
    .wb_hi         (wb_hi),
    .wb_lo         (wb_lo)
`endif
  );
  assign obs = {wb_valid, wb_wreg, wb_dest_addr, wb_dest_data};
  function automatic logic [76:0] ent(input logic v, input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a0,
                                      input logic [31:0] d1, input logic [31:0] d0);
    return {v, w, a1, a0, d1, d0};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic v, input logic [4:0] a0, input logic w0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic w1, input logic [31:0] d1);
    mem_valid = v;
    mem_dest_addr = {a1, a0};
    mem_wreg = {w1, w0};
    mem_dest_data = {d1, d0};
  endtask
  task automatic test_reset();
    exp = ent(0, 2'b00, 0, 0, 0, 0);
    checks++;
    if (obs !== exp || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init got=%h ready=%b exp=%h ready=1", obs, mem_ready, exp);
    end
    wb_ready = 1'b0;
    set_in(1, 5'd3, 1, 32'h11, 5'd0, 0, 32'h0);
    tick();
    set_in(1, 5'd4, 1, 32'h22, 5'd0, 0, 32'h0);
    tick();
    set_in(0, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_full_ready got=%b exp=0", mem_ready);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== exp || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got=%h ready=%b exp=%h ready=1", obs, mem_ready, exp);
    end
    wb_ready = 1'b1;
    tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_discard got=%h exp=%h", obs, exp);
    end
  endtask
  task automatic test_streaming();
    wb_ready = 1'b1;
    set_in(1, 5'd3, 1, 32'h11, 5'd0, 0, 32'h0);
    tick();
    exp = ent(1, 2'b01, 0, 3, 0, 32'h11);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stream_e1 got=%h exp=%h", obs, exp);
    end
    set_in(1, 5'd4, 1, 32'h22, 5'd0, 0, 32'h0);
    tick();
    exp = ent(1, 2'b01, 0, 4, 0, 32'h22);
    checks++;
    if (obs !== exp || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_e2 got=%h ready=%b exp=%h ready=1", obs, mem_ready, exp);
    end
    set_in(0, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    tick();
    exp = ent(0, 2'b00, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stream_drain got=%h exp=%h", obs, exp);
    end
  endtask
  task automatic test_backpressure();
    wb_ready = 1'b0;
    set_in(1, 5'd5, 1, 32'h1, 5'd0, 0, 32'h0);
    tick();
    exp = ent(1, 2'b01, 0, 5, 0, 32'h1);
    checks++;
    if (obs !== exp || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_one got=%h ready=%b exp=%h ready=1", obs, mem_ready, exp);
    end
    set_in(1, 5'd6, 1, 32'h2, 5'd0, 0, 32'h0);
    tick();
    checks++;
    if (obs !== exp || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got=%h ready=%b exp=%h ready=0", obs, mem_ready, exp);
    end
    set_in(1, 5'd7, 1, 32'h3, 5'd0, 0, 32'h0);
    tick();
    checks++;
    if (obs !== exp || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got=%h ready=%b exp=%h ready=0", obs, mem_ready, exp);
    end
    wb_ready = 1'b1;
    tick();
    exp = ent(1, 2'b01, 0, 6, 0, 32'h2);
    checks++;
    if (obs !== exp || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_deliver2 got=%h ready=%b exp=%h ready=1", obs, mem_ready, exp);
    end
    tick();
    set_in(0, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    exp = ent(1, 2'b01, 0, 7, 0, 32'h3);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_deliver3 got=%h exp=%h", obs, exp);
    end
    tick();
    exp = ent(0, 2'b00, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_drain got=%h exp=%h", obs, exp);
    end
  endtask
  task automatic test_sanitise();
    wb_ready = 1'b1;
    set_in(1, 5'd7, 1, 32'hA, 5'd7, 1, 32'hB);
    tick();
    exp = ent(1, 2'b10, 7, 7, 32'hB, 32'hA);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL san_collide got=%h exp=%h", obs, exp);
    end
    set_in(1, 5'd0, 1, 32'h5, 5'd9, 1, 32'h6);
    tick();
    exp = ent(1, 2'b10, 9, 0, 32'h6, 32'h5);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL san_zero got=%h exp=%h", obs, exp);
    end
    set_in(1, 5'd1, 1, 32'h7, 5'd2, 1, 32'h8);
    tick();
    exp = ent(1, 2'b11, 2, 1, 32'h8, 32'h7);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL san_distinct got=%h exp=%h", obs, exp);
    end
    set_in(0, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    tick();
  endtask
  task automatic test_flush();
    wb_ready = 1'b0;
    set_in(1, 5'd8, 1, 32'h8, 5'd0, 0, 32'h0);
    tick();
    exp = ent(1, 2'b01, 0, 8, 0, 32'h8);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL flush_pre got=%h exp=%h", obs, exp);
    end
    set_in(1, 5'd9, 1, 32'h9, 5'd0, 0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(0, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    exp = ent(0, 2'b00, 0, 0, 0, 0);
    checks++;
    if (obs !== exp || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty got=%h ready=%b exp=%h ready=1", obs, mem_ready, exp);
    end
    wb_ready = 1'b1;
    tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL flush_dropped got=%h exp=%h", obs, exp);
    end
  endtask
`ifdef MEM_WB_HILO_EN
  task automatic test_hilo();
    wb_ready = 1'b0;
    set_in(1, 5'd2, 1, 32'h4, 5'd0, 0, 32'h0);
    mem_whilo = 1'b1;
    mem_hi = 32'hDEAD;
    mem_lo = 32'hBEEF;
    tick();
    set_in(0, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
    mem_whilo = 1'b0;
    mem_hi = 32'h0;
    mem_lo = 32'h0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({wb_whilo, wb_hi, wb_lo} !== {1'b1, 32'hDEAD, 32'hBEEF}) begin
        errors++;
        $display("FAIL hilo_hold%0d got=%b/%h/%h exp=1/0000dead/0000beef", k, wb_whilo, wb_hi, wb_lo);
      end
      if (k < 2) tick();
    end
    wb_ready = 1'b1;
    tick();
    checks++;
    if ({wb_whilo, wb_hi, wb_lo} !== 65'b0) begin
      errors++;
      $display("FAIL hilo_popped got=%b/%h/%h exp=0/0/0", wb_whilo, wb_hi, wb_lo);
    end
  endtask
`endif
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    wb_ready = 1'b0;
    set_in(0, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
`ifdef MEM_WB_HILO_EN
    mem_whilo = 1'b0;
    mem_hi = 32'h0;
    mem_lo = 32'h0;
`endif
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_sanitise();
    test_flush();
`ifdef MEM_WB_HILO_EN
    test_hilo();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

- Parametrised MEM/WB pipeline stage that replaces the fixed single-register MEM/WB latch.
- Carries `LANES` independent register-write channels plus optional HI/LO writes from the memory stage to write-back.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, so a write-back stall never drops an instruction.
- Supports pipeline flush and in-stage write sanitising: `$0` suppression and same-cycle lane collision resolution.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `LANES`, 1, number of parallel write-back channels (1..4)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `flush`  in  1  discard all buffered entries
- `mem_valid`  in  1  memory stage presents an entry
- `mem_ready`  out  1  stage can accept an entry this cycle
- `mem_dest_addr`  in  LANES*ADDR_W  per-lane destination; lane i at bits [i*ADDR_W +: ADDR_W]
- `mem_wreg`  in  LANES  per-lane write enable
- `mem_dest_data`  in  LANES*DATA_W  per-lane write data
- `wb_valid`  out  1  head entry valid
- `wb_ready`  in  1  write-back consumes head entry
- `wb_dest_addr`  out  LANES*ADDR_W  head entry destinations
- `wb_wreg`  out  LANES  head entry write enables, already gated by `wb_valid`
- `wb_dest_data`  out  LANES*DATA_W  head entry data

## Operation
- Storage: head register `H` drives the `wb_*` outputs; skid register `S`.
- States:
  - EMPTY: H invalid, S invalid
  - ONE: H valid, S invalid
  - FULL: H valid, S valid
- `mem_ready` = state != FULL, registered (decoded from state).
- Accept condition: `mem_valid & mem_ready`. Pop condition: `wb_valid & wb_ready`.
- Transitions:
  - EMPTY, accept → ONE; H ← in.
  - ONE, accept and pop → ONE; H ← in.
  - ONE, accept only → FULL; S ← in.
  - ONE, pop only → EMPTY.
  - FULL, pop → ONE; H ← S. No accept is possible in FULL.
  - No accept and no pop → hold.
- Sanitise at capture, before storing:
  - Lane i with addr == 0 gets wreg cleared.
  - If lanes i < j both have wreg set with equal addr, lane i's wreg is cleared; the highest lane wins.
- `flush`, or `rst`, → EMPTY next edge. Flush overrides a simultaneous accept: the entry is dropped.
- When not `wb_valid`, outputs are `wb_wreg`=0, `wb_dest_addr`=0, `wb_dest_data`=0 (the NOP entry).
- Data registers of invalid entries are don't-care internally but never visible.

## Timing
- Latency: an entry accepted at edge N is presented on `wb_*` after edge N (visible in cycle N+1) when H is free.
- Throughput: 1 entry/cycle while `wb_ready` stays high.
- After a `wb_ready` drop, exactly one more entry is absorbed before `mem_ready` falls.
- `mem_ready` rises the cycle after the pop from FULL.
- Reset values, all outputs: `wb_valid`=0, `wb_wreg`=0, `wb_dest_addr`=0, `wb_dest_data`=0, `mem_ready`=1 (state EMPTY).
- Reset mid-operation discards H and S with no write-back.
- Flush and pop in the same cycle: the pop completes in that cycle (the consumer has sampled it); state → EMPTY.

## Configuration
- `MEM_WB_HILO_EN` defined: adds these ports:
  - `mem_whilo` in 1, `mem_hi` in DATA_W, `mem_lo` in DATA_W
  - `wb_whilo` out 1, `wb_hi` out DATA_W, `wb_lo` out DATA_W
- HI/LO fields travel through H/S exactly like lane data.
- `wb_whilo` is gated by `wb_valid` and resets to 0; `wb_hi`/`wb_lo` reset to 0.
- `MEM_WB_HILO_EN` undefined: ports and storage are absent; the behaviour is otherwise identical.

## Structure
- Shared package/defines:
  - `RegBus`/`RegAddrBus` widths as defaults.
  - `NOPRegAddr`, `ZeroWord`, `RstEnable`.
  - State encodings `WBQ_EMPTY`=2'b00, `WBQ_ONE`=2'b01, `WBQ_FULL`=2'b10.
  - Lane-slice helper constants.
- One sub-module: `wb_lane_sanitise`, combinational. Takes the LANES addr/wreg vectors and produces the sanitised wreg vector. Instantiated once, on the input side.

## Test plan
- Reset: assert `rst` 2 cycles mid-FULL → `wb_valid`=0, all `wb_*`=0, `mem_ready`=1 on the first post-reset cycle.
- Streaming, LANES=1, `wb_ready`=1: entries (addr 3, 0x11), (addr 4, 0x22) on consecutive cycles → each appears on `wb_*` one cycle later, no bubbles.
- Backpressure:
  - `wb_ready`=0 while 3 entries are offered → first held on `wb_*`, second absorbed into S, `mem_ready`=0, third held at input.
  - Raise `wb_ready` → entries delivered in order 1, 2, 3.
- Sanitise, LANES=2:
  - lane0 (addr 7, 0xA) and lane1 (addr 7, 0xB), both wreg → `wb_wreg`=2'b10.
  - Separate entry with lane0 addr 0, wreg=1 → `wb_wreg[0]`=0.
- Flush with simultaneous accept in ONE → next cycle `wb_valid`=0, the entry is never seen, `mem_ready`=1.
- `MEM_WB_HILO_EN`: entry with `mem_whilo`=1, hi 0xDEAD, lo 0xBEEF, stalled 2 cycles → `wb_whilo`=1 with those values until popped, then 0.
